// File: rtl/siso_shift_ctrl.sv
// siso_shift_ctrl: valid/ready-fed sequencer for a WIDTH-bit serial-in/serial-out shift register.
// Define SISO_SHIFT_CTRL_PARITY_EN to append an even-parity bit period to every word.
module siso_shift_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DIV   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic             abort,
  input  logic             sin,
  output logic             sout,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             rx_perr
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
`ifdef SISO_SHIFT_CTRL_PARITY_EN
  localparam int unsigned LAST_BIT = WIDTH;
`else
  localparam int unsigned LAST_BIT = WIDTH - 1;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] bit_cnt;
  logic [DIV_W-1:0] div_cnt;

  logic             tick;
  logic             last_bit;
  logic             data_phase;
  logic             accept;
  logic             finish;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] rx_word;
  logic             next_sout;

  assign tick       = (div_cnt == DIV_W'(DIV - 1));
  assign last_bit   = (bit_cnt == CNT_W'(LAST_BIT));
  assign data_phase = (bit_cnt < CNT_W'(WIDTH));
  assign accept     = (state == S_IDLE) && tx_valid && tx_ready;
  assign finish     = (state == S_SHIFT) && !abort && tick && last_bit;

  // The outgoing MSB drops off the top; sin enters at the bottom.
  assign shifted = WIDTH'({shreg, sin});

`ifdef SISO_SHIFT_CTRL_PARITY_EN
  logic tx_par;

  // Data is complete in shreg before the parity period, so it is captured unshifted.
  assign rx_word   = shreg;
  assign next_sout = (bit_cnt == CNT_W'(WIDTH - 1)) ? tx_par : shifted[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_par  <= 1'b0;
      rx_perr <= 1'b0;
    end else begin
      if (accept) begin
        tx_par <= ^tx_data;
      end
      if (finish) begin
        rx_perr <= sin ^ (^shreg);
      end
    end
  end
`else
  assign rx_word   = shifted;
  assign next_sout = shifted[WIDTH-1];
  assign rx_perr   = 1'b0;
`endif

  // Transfer sequencer with registered handshake and serial outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      div_cnt  <= '0;
      tx_ready <= 1'b1;
      sout     <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            shreg    <= tx_data;
            bit_cnt  <= '0;
            div_cnt  <= '0;
            sout     <= tx_data[WIDTH-1];
            tx_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (abort) begin
            sout     <= 1'b0;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end else if (tick) begin
            div_cnt <= '0;
            if (data_phase) begin
              shreg   <= shifted;
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (last_bit) begin
              sout     <= 1'b0;
              rx_data  <= rx_word;
              rx_valid <= 1'b1;
              state    <= S_DONE;
            end else begin
              sout <= next_sout;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        S_DONE: begin
          tx_ready <= 1'b1;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          sout     <= 1'b0;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_siso_shift_ctrl.sv
// tb_siso_shift_ctrl: self-checking bench for siso_shift_ctrl (DIV=1 and DIV=3 instances side by side).
// Honours SISO_SHIFT_CTRL_PARITY_EN the same way the design does.
`timescale 1ns/1ps
module tb_siso_shift_ctrl;

  localparam int unsigned WIDTH = 4;
`ifdef SISO_SHIFT_CTRL_PARITY_EN
  localparam int unsigned PAR = 1;
`else
  localparam int unsigned PAR = 0;
`endif
  localparam int unsigned NB = WIDTH + PAR;

  typedef struct {
    int               sel;
    logic [WIDTH-1:0] word;
    bit               loop;
    logic [WIDTH:0]   seq;
    logic [WIDTH-1:0] exp_rx;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] tx_data  [2];
  logic             tx_valid [2];
  logic             tx_ready [2];
  logic             abort    [2];
  logic             sin      [2];
  logic             sout     [2];
  logic [WIDTH-1:0] rx_data  [2];
  logic             rx_valid [2];
  logic             busy     [2];
  logic             rx_perr  [2];
  logic [WIDTH-1:0] last_rx  [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  siso_shift_ctrl #(.WIDTH(WIDTH), .DIV(1)) u_div1 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .abort(abort[0]), .sin(sin[0]), .sout(sout[0]),
    .rx_data(rx_data[0]), .rx_valid(rx_valid[0]), .busy(busy[0]), .rx_perr(rx_perr[0])
  );

  siso_shift_ctrl #(.WIDTH(WIDTH), .DIV(3)) u_div3 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .abort(abort[1]), .sin(sin[1]), .sout(sout[1]),
    .rx_data(rx_data[1]), .rx_valid(rx_valid[1]), .busy(busy[1]), .rx_perr(rx_perr[1])
  );

  function automatic int div_of(input int sel);
    return (sel == 0) ? 1 : 3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset(input int sel);
    check("rst_tx_ready", 32'(tx_ready[sel]), 32'd1);
    check("rst_sout",     32'(sout[sel]),     32'd0);
    check("rst_rx_data",  32'(rx_data[sel]),  32'd0);
    check("rst_rx_valid", 32'(rx_valid[sel]), 32'd0);
    check("rst_busy",     32'(busy[sel]),     32'd0);
    check("rst_rx_perr",  32'(rx_perr[sel]),  32'd0);
  endtask

  // One full transfer; seq holds the sin bit per period, MSB-first, parity slot in seq[0].
  task automatic run_word(input int sel, input logic [WIDTH-1:0] word, input logic [WIDTH:0] seq,
                          input logic [WIDTH-1:0] exp_rx, input logic exp_perr);
    int d;
    int k;
    logic [WIDTH:0] sbits;
    d = div_of(sel);
    sbits = {word, ^word};
    check("idle_tx_ready", 32'(tx_ready[sel]), 32'd1);
    tx_valid[sel] = 1'b1;
    tx_data[sel]  = word;
    @(posedge clk);
    @(negedge clk);
    tx_valid[sel] = 1'b0;
    tx_data[sel]  = ~word;
    for (int c = 0; c < int'(NB) * d; c++) begin
      k = c / d;
      check("sout_bit",       32'(sout[sel]),     32'(sbits[WIDTH-k]));
      check("shift_busy",     32'(busy[sel]),     32'd1);
      check("shift_tx_ready", 32'(tx_ready[sel]), 32'd0);
      check("shift_rx_valid", 32'(rx_valid[sel]), 32'd0);
      sin[sel] = seq[WIDTH-k];
      @(negedge clk);
    end
    check("done_rx_valid", 32'(rx_valid[sel]), 32'd1);
    check("done_rx_data",  32'(rx_data[sel]),  32'(exp_rx));
    check("done_rx_perr",  32'(rx_perr[sel]),  32'(exp_perr));
    check("done_sout",     32'(sout[sel]),     32'd0);
    check("done_busy",     32'(busy[sel]),     32'd1);
    check("done_tx_ready", 32'(tx_ready[sel]), 32'd0);
    last_rx[sel] = exp_rx;
    @(negedge clk);
    check("post_rx_valid", 32'(rx_valid[sel]), 32'd0);
    check("post_tx_ready", 32'(tx_ready[sel]), 32'd1);
    check("post_busy",     32'(busy[sel]),     32'd0);
  endtask

  // tx_valid held high across two words with sin looped back from sout.
  task automatic back_to_back();
    int hs [$];
    logic [WIDTH-1:0] rxs [$];
    logic perrs [$];
    logic hs_now;
    tx_valid[0] = 1'b1;
    tx_data[0]  = 4'hA;
    for (int t = 0; t < 3 * int'(NB + 2); t++) begin
      sin[0] = sout[0];
      if (rx_valid[0]) begin
        rxs.push_back(rx_data[0]);
        perrs.push_back(rx_perr[0]);
      end
      hs_now = tx_valid[0] && tx_ready[0];
      @(negedge clk);
      if (hs_now) begin
        hs.push_back(t);
        if (hs.size() == 1) tx_data[0] = 4'h5;
        else tx_valid[0] = 1'b0;
      end
    end
    tx_valid[0] = 1'b0;
    check("b2b_handshakes", 32'(hs.size()), 32'd2);
    check("b2b_rx_pulses",  32'(rxs.size()), 32'd2);
    if (hs.size() == 2) check("b2b_period", 32'(hs[1] - hs[0]), 32'(NB + 2));
    if (rxs.size() == 2) begin
      check("b2b_rx0",   32'(rxs[0]),   32'hA);
      check("b2b_rx1",   32'(rxs[1]),   32'h5);
      check("b2b_perr0", 32'(perrs[0]), 32'd0);
      check("b2b_perr1", 32'(perrs[1]), 32'd0);
    end
    last_rx[0] = 4'h5;
  endtask

  // Abort asserted in the cycle before edge E0+at_cycle; expects IDLE with nothing received.
  task automatic abort_at(input int sel, input logic [WIDTH-1:0] word, input int at_cycle);
    int seen;
    seen = 0;
    tx_valid[sel] = 1'b1;
    tx_data[sel]  = word;
    sin[sel]      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid[sel] = 1'b0;
    repeat (at_cycle - 1) @(negedge clk);
    abort[sel] = 1'b1;
    @(negedge clk);
    abort[sel] = 1'b0;
    check("abort_sout",     32'(sout[sel]),     32'd0);
    check("abort_tx_ready", 32'(tx_ready[sel]), 32'd1);
    check("abort_busy",     32'(busy[sel]),     32'd0);
    check("abort_rx_valid", 32'(rx_valid[sel]), 32'd0);
    check("abort_rx_data",  32'(rx_data[sel]),  32'(last_rx[sel]));
    for (int t = 0; t < int'(NB) * div_of(sel) + 4; t++) begin
      if (rx_valid[sel]) seen++;
      @(negedge clk);
    end
    check("abort_no_rx", 32'(seen), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [6];
    logic [WIDTH:0]   sq;
    logic [WIDTH-1:0] w;
    logic             ep;
    int               sel;
    int               seen;

    vecs[0] = '{0, 4'b1011, 1'b1, 5'b00000, 4'b1011};
    vecs[1] = '{1, 4'b0000, 1'b0, 5'b11111, 4'b1111};
    vecs[2] = '{0, 4'b1011, 1'b0, 5'b10110, 4'b1011};
    vecs[3] = '{1, 4'b1100, 1'b0, 5'b01101, 4'b0110};
    vecs[4] = '{0, 4'b0001, 1'b0, 5'b10001, 4'b1000};
    vecs[5] = '{1, 4'b1111, 1'b1, 5'b00000, 4'b1111};

    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      tx_valid[s] = 1'b0;
      tx_data[s]  = '0;
      abort[s]    = 1'b0;
      sin[s]      = 1'b0;
      last_rx[s]  = '0;
    end
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) check_reset(s);
    rst_n = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 2; s++) check_reset(s);

    for (int i = 0; i < 6; i++) begin
      sq = vecs[i].loop ? {vecs[i].word, ^vecs[i].word} : vecs[i].seq;
      ep = (PAR != 0) ? (sq[0] ^ (^vecs[i].exp_rx)) : 1'b0;
      run_word(vecs[i].sel, vecs[i].word, sq, vecs[i].exp_rx, ep);
    end

    back_to_back();
    abort_at(1, 4'h6, 2 * 3 + 1);
    abort_at(0, 4'hF, int'(NB));

    for (int i = 0; i < 60; i++) begin
      sel = int'($urandom_range(0, 1));
      w   = WIDTH'($urandom);
      sq  = (WIDTH + 1)'($urandom);
      if ($urandom_range(0, 3) == 0) sq = {w, ^w};
      ep  = (PAR != 0) ? (sq[0] ^ (^sq[WIDTH:1])) : 1'b0;
      run_word(sel, w, sq, sq[WIDTH:1], ep);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Asynchronous reset in the middle of a shift, between clock edges.
    tx_valid[0] = 1'b1;
    tx_data[0]  = 4'h9;
    @(posedge clk);
    @(negedge clk);
    tx_valid[0] = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) check_reset(s);
    @(negedge clk);
    rst_n = 1'b1;
    last_rx[0] = '0;
    last_rx[1] = '0;
    seen = 0;
    for (int t = 0; t < int'(NB) * 3 + 4; t++) begin
      if (rx_valid[0] || rx_valid[1]) seen++;
      @(negedge clk);
    end
    check("rst_no_rx", 32'(seen), 32'd0);
    check("rst_rx_data_hold", 32'(rx_data[0]), 32'd0);
    check("rst_ready_after",  32'(tx_ready[0]), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
